// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one single-port DRAM among NUM_CORES cores, one access in flight at a time.
// Define DRAM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no rr pointer); default is round-robin.
module dram_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  localparam int GW       = $clog2(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        dram_we,
  output logic [ADDR_W-1:0]           dram_addr,
  output logic [DATA_W-1:0]           dram_wdata,
  input  logic [DATA_W-1:0]           dram_rdata,
  output logic [GW-1:0]               grant_id,
  output logic                        busy
);

  // state  | meaning
  // IDLE   | arbitrate among requesters, latch winner's access onto the DRAM port
  // ACCESS | DRAM samples the port at the closing edge
  // WAIT   | DRAM read data valid; capture it and raise ack
  // DONE   | ack pulse high for the granted core
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic                  dram_we_q, dram_we_d;
  logic [ADDR_W-1:0]     dram_addr_q, dram_addr_d;
  logic [DATA_W-1:0]     dram_wdata_q, dram_wdata_d;
  logic [NUM_CORES-1:0]  core_ack_q, core_ack_d;
  logic [DATA_W-1:0]     core_rdata_q, core_rdata_d;
  logic [GW-1:0]         grant_id_q, grant_id_d;
  logic                  busy_q, busy_d;
  logic                  acc_we_q, acc_we_d;
  logic                  found;
  logic [GW-1:0]         win;
  logic [GW-1:0]         sel;
`ifndef DRAM_ARB_FIXED_PRIO_EN
  logic [GW-1:0]         rr_q, rr_d;
`endif

  // First requester found while scanning upward from the search start.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sel   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
      sel = GW'(i);
`else
      sel = GW'((int'(rr_q) + i) % NUM_CORES);
`endif
      if (!found && core_req[sel]) begin
        found = 1'b1;
        win   = sel;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    dram_we_d    = dram_we_q;
    dram_addr_d  = dram_addr_q;
    dram_wdata_d = dram_wdata_q;
    core_ack_d   = '0;
    core_rdata_d = core_rdata_q;
    grant_id_d   = grant_id_q;
    acc_we_d     = acc_we_q;
`ifndef DRAM_ARB_FIXED_PRIO_EN
    rr_d         = rr_q;
`endif
    case (state_q)
      IDLE: begin
        dram_we_d = 1'b0;
        if (found) begin
          dram_addr_d  = core_addr[int'(win)*ADDR_W +: ADDR_W];
          dram_wdata_d = core_wdata[int'(win)*DATA_W +: DATA_W];
          dram_we_d    = core_we[win];
          acc_we_d     = core_we[win];
          grant_id_d   = win;
`ifndef DRAM_ARB_FIXED_PRIO_EN
          rr_d         = GW'((int'(win) + 1) % NUM_CORES);
`endif
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        dram_we_d = 1'b0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (!acc_we_q) core_rdata_d = dram_rdata;
        core_ack_d[grant_id_q] = 1'b1;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dram_we_q    <= 1'b0;
      dram_addr_q  <= '0;
      dram_wdata_q <= '0;
      core_ack_q   <= '0;
      core_rdata_q <= '0;
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
      acc_we_q     <= 1'b0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
      rr_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dram_we_q    <= dram_we_d;
      dram_addr_q  <= dram_addr_d;
      dram_wdata_q <= dram_wdata_d;
      core_ack_q   <= core_ack_d;
      core_rdata_q <= core_rdata_d;
      grant_id_q   <= grant_id_d;
      busy_q       <= busy_d;
      acc_we_q     <= acc_we_d;
`ifndef DRAM_ARB_FIXED_PRIO_EN
      rr_q         <= rr_d;
`endif
    end
  end

  assign core_ack   = core_ack_q;
  assign core_rdata = core_rdata_q;
  assign dram_we    = dram_we_q;
  assign dram_addr  = dram_addr_q;
  assign dram_wdata = dram_wdata_q;
  assign grant_id   = grant_id_q;
  assign busy       = busy_q;

endmodule
